vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing generator for the 1280x1024@60 VGA path (108 MHz pixel rate). Produces the
//  raw pixel counters pix_x/pix_y consumed by the text-overlay/colour stage, plus hsync, vsync
//  and the active-video flag driven to the connector. Counter origin is the start of sync,
//  so the visible window is x 360..1639, y 41..1064.
// PARAMETERS
//  H_SYNC    112   hsync width, pixels
//  H_BP      248   horizontal back porch
//  H_ACTIVE  1280  visible pixels per line
//  H_FP      48    horizontal front porch (H_TOTAL = 1688)
//  V_SYNC    3     vsync width, lines
//  V_BP      38    vertical back porch
//  V_ACTIVE  1024  visible lines
//  V_FP      1     vertical front porch (V_TOTAL = 1066)
//  SYNC_POL  1     asserted level of hsync/vsync (1 = positive, as 1280x1024@60 requires)
// PORTS
//  clk          in   1   pixel-domain clock
//  rst_n        in   1   asynchronous reset, active low
//  pix_ce       in   1   pixel advance enable (tie 1 at 108 MHz; strobe if clk is faster)
//  pix_x        out  11  horizontal count 0..H_TOTAL-1
//  pix_y        out  11  vertical count 0..V_TOTAL-1
//  hsync        out  1   horizontal sync, level SYNC_POL while asserted
//  vsync        out  1   vertical sync, level SYNC_POL while asserted
//  video_on     out  1   1 inside the visible window
//  line_end     out  1   1-clk pulse when pix_x = H_TOTAL-1 and pix_ce = 1
//  frame_start  out  1   1-clk pulse on the pix_ce that moves (pix_x,pix_y) to (0,0)
// BEHAVIOUR
//  - Reset (rst_n low, async): pix_x=0, pix_y=0, hsync=vsync=SYNC_POL, video_on=0,
//    line_end=0, frame_start=0. Release is synchronous to clk; first advance on next pix_ce.
//  - pix_ce=0: all counters and outputs hold; line_end/frame_start forced 0.
//  - pix_ce=1: pix_x increments; at H_TOTAL-1 wraps to 0 and pix_y increments;
//    at (H_TOTAL-1, V_TOTAL-1) both wrap to 0 in the same cycle. Counters never exceed totals.
//  - hsync/vsync/video_on are registered, computed from next-count, so they are cycle-aligned
//    with pix_x/pix_y (zero relative latency):
//      hsync    = SYNC_POL  when pix_x <  H_SYNC,          else ~SYNC_POL
//      vsync    = SYNC_POL  when pix_y <  V_SYNC,          else ~SYNC_POL
//      video_on = 1 when H_SYNC+H_BP <= pix_x < H_SYNC+H_BP+H_ACTIVE
//                    and V_SYNC+V_BP <= pix_y < V_SYNC+V_BP+V_ACTIVE
//  - Comparisons unsigned 11-bit; parameter sums must fit 11 bits (elaboration check).
//  - Reset asserted mid-frame: immediate return to reset values; no partial-line completion.
//  - frame_start and line_end coincide on the final pixel of a frame.
// CONFIGURATION
//  VGA_SYNC_PIPE_EN defined: hsync, vsync, video_on pass through one extra register
//   stage advanced by pix_ce, lagging pix_x/pix_y by exactly one pixel to match the
//   registered font-ROM read in the overlay path. Reset value of the stage = reset values above.
//  Not defined: outputs aligned to counters as specified above, no extra stage.
// STRUCTURE
//  - Package vga_timing_pkg: default timing localparams (H_/V_ values, totals,
//    active start/end constants), counter width constant (11).
//  - Sub-module vga_axis_counter (wrap counter with enable, terminal-count output),
//    instantiated twice: horizontal (en = pix_ce), vertical (en = pix_ce & h terminal).
//  - Sync/video decode and optional pipe stage in the top module.
// TESTING
//  - Reset, pix_ce=1 for 5 clks -> pix_x=5, pix_y=0, hsync=1, video_on=0.
//  - Run to pix_x=1687 -> line_end=1 that cycle; next cycle pix_x=0, pix_y=1.
//  - Full frame -> exactly 1688*1066=1,799,408 ce per frame_start; hsync high 112 px/line,
//    vsync high 3 lines; video_on high 1280*1024 px, first at (360,41), last at (1639,1064).
//  - pix_ce toggled 1/0 alternating -> counters advance every other clk, frame length doubles.
//  - rst_n low at (900,500) for 3 clks -> (0,0), hsync=vsync=1 asynchronously, resumes cleanly.
//  - VGA_SYNC_PIPE_EN -> video_on rises on clk after pix_x=360 at pix_y=41; hsync falls at pix_x=113.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 1280x1024@60 raster timing constants and shared types for the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 11;

  localparam int unsigned DEF_H_SYNC   = 112;
  localparam int unsigned DEF_H_BP     = 248;
  localparam int unsigned DEF_H_ACTIVE = 1280;
  localparam int unsigned DEF_H_FP     = 48;
  localparam int unsigned DEF_V_SYNC   = 3;
  localparam int unsigned DEF_V_BP     = 38;
  localparam int unsigned DEF_V_ACTIVE = 1024;
  localparam int unsigned DEF_V_FP     = 1;

  localparam int unsigned DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

  // Counter origin is the start of sync, so the visible window starts after sync + back porch.
  localparam int unsigned DEF_H_ACT_START = DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_H_ACT_END   = DEF_H_ACT_START + DEF_H_ACTIVE;
  localparam int unsigned DEF_V_ACT_START = DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned DEF_V_ACT_END   = DEF_V_ACT_START + DEF_V_ACTIVE;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping raster axis counter: counts 0..TOTAL-1 while enabled, flags the terminal count
// and exposes the next count so downstream decode can be registered in step with it.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL = DEF_H_TOTAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output cnt_t count_o,
  output cnt_t count_nxt_o,
  output logic tc_o
);

  localparam cnt_t LAST = cnt_t'(TOTAL - 1);

  cnt_t count_q;
  cnt_t count_d;

  assign tc_o = (count_q == LAST);

  // NOTE: combinational blocks assign a default first so no path can leave a latch behind.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = tc_o ? '0 : count_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign count_nxt_o = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator (pixel counters, hsync/vsync, active-video flag).
// Define VGA_SYNC_PIPE_EN to delay hsync/vsync/video_on by one pixel behind pix_x/pix_y.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_end,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_timing
    $error("vga_timing_gen: line/frame totals do not fit the counter width");
  end

  localparam cnt_t H_SYNC_END  = cnt_t'(H_SYNC);
  localparam cnt_t H_ACT_START = cnt_t'(H_SYNC + H_BP);
  localparam cnt_t H_ACT_END   = cnt_t'(H_SYNC + H_BP + H_ACTIVE);
  localparam cnt_t V_SYNC_END  = cnt_t'(V_SYNC);
  localparam cnt_t V_ACT_START = cnt_t'(V_SYNC + V_BP);
  localparam cnt_t V_ACT_END   = cnt_t'(V_SYNC + V_BP + V_ACTIVE);

  localparam sync_t SYNC_RST = '{hsync: SYNC_POL, vsync: SYNC_POL, video_on: 1'b0};

  cnt_t  x_nxt;
  cnt_t  y_nxt;
  logic  h_tc;
  logic  v_tc;
  sync_t sync_d;
  sync_t sync_q;
  sync_t sync_out;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (pix_ce),
    .count_o    (pix_x),
    .count_nxt_o(x_nxt),
    .tc_o       (h_tc)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (pix_ce & h_tc),
    .count_o    (pix_y),
    .count_nxt_o(y_nxt),
    .tc_o       (v_tc)
  );

  // Decoding the next count makes the registered flags land in the same cycle as the counters.
  always_comb begin
    sync_d          = SYNC_RST;
    sync_d.hsync    = (x_nxt < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    sync_d.vsync    = (y_nxt < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    sync_d.video_on = (x_nxt >= H_ACT_START) && (x_nxt < H_ACT_END) &&
                      (y_nxt >= V_ACT_START) && (y_nxt < V_ACT_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= SYNC_RST;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef VGA_SYNC_PIPE_EN
  sync_t pipe_d;
  sync_t pipe_q;

  always_comb begin
    pipe_d = pipe_q;
    if (pix_ce) begin
      pipe_d = sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= SYNC_RST;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign sync_out = pipe_q;
`else
  assign sync_out = sync_q;
`endif

  assign hsync       = sync_out.hsync;
  assign vsync       = sync_out.vsync;
  assign video_on    = sync_out.video_on;
  assign line_end    = pix_ce & h_tc;
  assign frame_start = pix_ce & h_tc & v_tc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 1280x1024 timing for line-level checks, plus a shrunken raster
// (17x10) for whole-frame statistics, pix_ce strobing and mid-frame reset.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

`ifdef VGA_SYNC_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  // Shrunken raster: H 4+3+8+2 = 17, V 2+2+5+1 = 10, 170 pixels per frame.
  localparam int SH_TOT = 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce_a;
  logic        ce_b;
  logic [10:0] a_x, a_y, b_x, b_y;
  logic        a_hs, a_vs, a_vid, a_le, a_fs;
  logic        b_hs, b_vs, b_vid, b_le, b_fs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_ce     (ce_a),
    .pix_x      (a_x),
    .pix_y      (a_y),
    .hsync      (a_hs),
    .vsync      (a_vs),
    .video_on   (a_vid),
    .line_end   (a_le),
    .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(1),
    .SYNC_POL(1'b1)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_ce     (ce_b),
    .pix_x      (b_x),
    .pix_y      (b_y),
    .hsync      (b_hs),
    .vsync      (b_vs),
    .video_on   (b_vid),
    .line_end   (b_le),
    .frame_start(b_fs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_a_to(input int x, input int limit);
    int n = 0;
    while (int'(a_x) != x && n < limit) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("a_reach_x%0d", x), a_x, x);
  endtask

  task automatic run_b_to(input int x, input int y, input int limit);
    int n = 0;
    while (!(int'(b_x) == x && int'(b_y) == y) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("b_reach_x", b_x, x);
    check("b_reach_y", b_y, y);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n, pos, hs_n, vs_n, vid_n, le_n, max_x, max_y, first_vid, last_vid;

    rst_n = 1'b0;
    ce_a  = 1'b0;
    ce_b  = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_x", a_x, 0);
    check("rst_y", a_y, 0);
    check("rst_hsync", a_hs, 1);
    check("rst_vsync", a_vs, 1);
    check("rst_video_on", a_vid, 0);
    check("rst_line_end", a_le, 0);
    check("rst_frame_start", a_fs, 0);

    // Five enabled pixels after release.
    rst_n = 1'b1;
    ce_a  = 1'b1;
    repeat (5) @(negedge clk);
    check("x_after5", a_x, 5);
    check("y_after5", a_y, 0);
    check("hsync_after5", a_hs, 1);
    check("video_after5", a_vid, 0);

    // hsync edge at the end of the 112-pixel sync pulse.
    run_a_to(111, 300);
    check("hsync_x111", a_hs, 1);
    @(negedge clk);
    check("hsync_x112", a_hs, PIPE);
    @(negedge clk);
    check("x113", a_x, 113);
    check("hsync_x113", a_hs, 0);

    // Line end at x=1687, including a pix_ce=0 hold on that pixel.
    run_a_to(DEF_H_TOTAL - 2, 2000);
    check("line_end_x1686", a_le, 0);
    @(negedge clk);
    check("x_last", a_x, 1687);
    check("line_end_x1687", a_le, 1);
    check("frame_start_x1687", a_fs, 0);
    ce_a = 1'b0;
    #1;
    check("line_end_ce0", a_le, 0);
    @(negedge clk);
    check("hold_x", a_x, 1687);
    check("hold_y", a_y, 0);
    ce_a = 1'b1;
    #1;
    check("line_end_ce1", a_le, 1);
    @(negedge clk);
    check("wrap_x", a_x, 0);
    check("wrap_y", a_y, 1);
    check("wrap_line_end", a_le, 0);
    check("wrap_hsync", a_hs, 1 - PIPE);
    check("wrap_vsync", a_vs, 1);
    run_a_to(DEF_H_ACT_START, 500);
    check("video_line1", a_vid, 0);
    ce_a = 1'b0;

    // Small raster: align to the last pixel of a frame.
    ce_b = 1'b1;
    #1;
    n = 0;
    while (!b_fs && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("b_fs_seen", b_fs, 1);
    check("b_fs_with_le", b_le, 1);
    check("b_fs_x", b_x, 16);
    check("b_fs_y", b_y, 9);

    // One full frame at pix_ce=1: gather per-pixel statistics.
    cyc = 0; hs_n = 0; vs_n = 0; vid_n = 0; le_n = 0; max_x = 0; max_y = 0;
    first_vid = -1; last_vid = -1;
    do begin
      @(negedge clk);
      #1;
      cyc++;
      pos = int'(b_y) * SH_TOT + int'(b_x);
      if (b_hs) hs_n++;
      if (b_vs) vs_n++;
      if (b_le) le_n++;
      if (b_vid) begin
        vid_n++;
        if (first_vid < 0) first_vid = pos;
        last_vid = pos;
      end
      if (int'(b_x) > max_x) max_x = int'(b_x);
      if (int'(b_y) > max_y) max_y = int'(b_y);
    end while (!b_fs && cyc < 1000);
    check("frame_len", cyc, 170);
    check("hsync_px", hs_n, 40);
    check("vsync_px", vs_n, 34);
    check("video_px", vid_n, 40);
    check("line_ends", le_n, 10);
    check("first_video_pos", first_vid, 4 * SH_TOT + 7 + PIPE);
    check("last_video_pos", last_vid, 8 * SH_TOT + 14 + PIPE);
    check("max_x", max_x, 16);
    check("max_y", max_y, 9);

    // Alternating pix_ce doubles the frame length.
    cyc = 0;
    do begin
      @(negedge clk);
      ce_b = ~ce_b;
      #1;
      cyc++;
    end while (!b_fs && cyc < 1000);
    check("frame_len_half_rate", cyc, 340);

    // Asynchronous reset in the middle of a frame, away from any clock edge.
    ce_b = 1'b1;
    run_b_to(9, 5, 400);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_x", b_x, 0);
    check("async_rst_y", b_y, 0);
    check("async_rst_hsync", b_hs, 1);
    check("async_rst_vsync", b_vs, 1);
    check("async_rst_video", b_vid, 0);
    repeat (3) @(negedge clk);
    check("rst_hold_x", b_x, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("resume_x", b_x, 5);
    check("resume_y", b_y, 0);
    check("resume_hsync", b_hs, 0);
    check("resume_vsync", b_vs, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
